// File: rtl/step_sequencer3_pkg.sv
// -----------------------------------------------------------------------------
// step_seq_pkg
// Shared definitions for the step_sequencer3 index generator.
//   mode_e   : 2-bit step mode (up / down / ping-pong / hold)
//   dir_e    : ping-pong travel direction
//   SEL_W    : width of the decoder select index
//   SEL_MAX  : highest index value (top endpoint of every sequence)
// -----------------------------------------------------------------------------
package step_seq_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;
    localparam logic [SEL_W-1:0] SEL_MIN = 3'd0;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } dir_e;

    // Result of one step: next index, next direction and whether this step
    // completes a full sequence.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        dir_e             dir;
        logic             wrap;
    } step_t;

    // Ping-pong step: walk in the current direction and bounce off the
    // endpoints without repeating them. The bounce at the bottom closes a
    // full pass, so it raises wrap.
    function automatic step_t pingpong_step(input logic [SEL_W-1:0] cur_sel,
                                            input dir_e             cur_dir);
        step_t res;
        res.sel  = cur_sel;
        res.dir  = cur_dir;
        res.wrap = 1'b0;
        if (cur_dir == DIR_ASC) begin
            if (cur_sel == SEL_MAX) begin
                res.sel = SEL_MAX - 3'd1;
                res.dir = DIR_DESC;
            end else begin
                res.sel = cur_sel + 3'd1;
            end
        end else begin
            if (cur_sel == SEL_MIN) begin
                res.sel  = SEL_MIN + 3'd1;
                res.dir  = DIR_ASC;
                res.wrap = 1'b1;
            end else begin
                res.sel = cur_sel - 3'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/step_sequencer3_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Prescaler that turns PRESCALE enabled clock cycles into one tick.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (count returns to 0)
//   en     in  advance enable; the count is frozen while low
//   clear  in  synchronous clear of the partial count (wins over en)
//   tick   out high on the enabled cycle that completes a prescale period
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] count;

    // tick is combinational so the sequencer can step on the same edge that
    // closes the prescale period; the sequencer registers everything it drives.
    assign tick = en && (count == LAST);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + PS_W'(1);
        end
    end

endmodule

// File: rtl/step_sequencer3.sv
// -----------------------------------------------------------------------------
// step_sequencer3
// Clocked 3-bit index generator feeding the select inputs of a 3-to-8 LED
// decoder, so exactly one LED is lit and the lit LED steps over time.
//   clk         in   system clock, rising-edge active
//   rst_n       in   asynchronous active-low reset
//   en          in   prescaler advance enable
//   mode        in   00 up, 01 down, 10 ping-pong, 11 hold
//   load        in   synchronous load strobe (priority over a step)
//   load_val    in   value loaded into sel
//   sel         out  current index (registered)
//   dir         out  ping-pong direction, 0 ascending / 1 descending (registered)
//   step_pulse  out  one-cycle strobe when sel takes a stepped value
//   wrap        out  one-cycle strobe when a full sequence completes
// -----------------------------------------------------------------------------
module step_sequencer3
    import step_seq_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    output logic [SEL_W-1:0] sel,
    output logic             dir,
    output logic             step_pulse,
    output logic             wrap
);

    logic  tick;
    dir_e  dir_q;
    mode_e mode_q;

    logic [SEL_W-1:0] sel_nxt;
    dir_e             dir_nxt;
    logic             wrap_nxt;
    logic             step_nxt;
    step_t            pp;

    // A load restarts the step period, so it also clears the partial count.
    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clear (load),
        .tick  (tick)
    );

    assign mode_q = mode_e'(mode);
    assign pp     = pingpong_step(sel, dir_q);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        sel_nxt  = sel;
        dir_nxt  = dir_q;
        wrap_nxt = 1'b0;
        step_nxt = 1'b0;
        if (tick) begin
            unique case (mode_q)
                MODE_UP: begin
                    sel_nxt  = sel + 3'd1;
                    wrap_nxt = (sel == SEL_MAX);
                    step_nxt = 1'b1;
                end
                MODE_DOWN: begin
                    sel_nxt  = sel - 3'd1;
                    wrap_nxt = (sel == SEL_MIN);
                    step_nxt = 1'b1;
                end
                MODE_PINGPONG: begin
                    sel_nxt  = pp.sel;
                    dir_nxt  = pp.dir;
                    wrap_nxt = pp.wrap;
                    step_nxt = 1'b1;
                end
                MODE_HOLD: begin
                    // Prescaler keeps running; index and strobes stay put.
                end
            endcase
        end
    end

    // Load wins over a coincident tick and suppresses that cycle's strobes.
    // dir survives mode changes and only matters in ping-pong.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= SEL_MIN;
            dir_q      <= DIR_ASC;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
        end else if (load) begin
            sel        <= load_val;
            dir_q      <= DIR_ASC;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            sel        <= sel_nxt;
            dir_q      <= dir_nxt;
            step_pulse <= step_nxt;
            wrap       <= wrap_nxt;
        end
    end

    assign dir = (dir_q == DIR_DESC);

endmodule

// File: tb/tb_step_sequencer3.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer3
// Drives two sequencers (PRESCALE=4 and PRESCALE=1) from the same inputs and
// compares every output each cycle with a behavioural model of the index
// generator, plus directed checks on the interesting corners.
// -----------------------------------------------------------------------------
module tb_step_sequencer3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic [2:0] sel_o [2];
    logic       dir_o [2];
    logic       sp_o  [2];
    logic       wr_o  [2];

    always #5 clk = ~clk;

    step_sequencer3 #(.PRESCALE(4)) u_dut_ps4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
        .sel        (sel_o[0]),
        .dir        (dir_o[0]),
        .step_pulse (sp_o[0]),
        .wrap       (wr_o[0])
    );

    step_sequencer3 #(.PRESCALE(1)) u_dut_ps1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
        .sel        (sel_o[1]),
        .dir        (dir_o[1]),
        .step_pulse (sp_o[1]),
        .wrap       (wr_o[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model state, one slot per instance.
    int m_sel [2];
    int m_dir [2];
    int m_ps  [2];
    int m_sp  [2];
    int m_wr  [2];

    function automatic int prescale_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0;
            m_dir[k] = 0;
            m_ps[k]  = 0;
            m_sp[k]  = 0;
            m_wr[k]  = 0;
        end
    endtask

    // One rising edge of the model, using the inputs present before the edge.
    task automatic model_edge(input int k);
        bit tick;
        int step;
        m_sp[k] = 0;
        m_wr[k] = 0;
        if (load) begin
            m_sel[k] = int'(load_val);
            m_dir[k] = 0;
            m_ps[k]  = 0;
        end else if (en) begin
            tick = (m_ps[k] == prescale_of(k) - 1);
            m_ps[k] = tick ? 0 : m_ps[k] + 1;
            if (tick && mode != 2'b11) begin
                m_sp[k] = 1;
                case (mode)
                    2'b00: begin
                        m_wr[k]  = (m_sel[k] == 7);
                        m_sel[k] = (m_sel[k] + 1) % 8;
                    end
                    2'b01: begin
                        m_wr[k]  = (m_sel[k] == 0);
                        m_sel[k] = (m_sel[k] + 7) % 8;
                    end
                    default: begin
                        step = (m_dir[k] != 0) ? -1 : 1;
                        if (m_sel[k] + step < 0 || m_sel[k] + step > 7) begin
                            step     = -step;
                            m_dir[k] = 1 - m_dir[k];
                            m_wr[k]  = (m_dir[k] == 0);
                        end
                        m_sel[k] = m_sel[k] + step;
                    end
                endcase
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("sel[%0d]", k),  int'(sel_o[k]), m_sel[k]);
            check($sformatf("dir[%0d]", k),  int'(dir_o[k]), m_dir[k]);
            check($sformatf("step[%0d]", k), int'(sp_o[k]),  m_sp[k]);
            check($sformatf("wrap[%0d]", k), int'(wr_o[k]),  m_wr[k]);
        end
    endtask

    // Advance one clock: model follows the edge, outputs sampled 1 ns later.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) model_edge(k);
        end
        #1;
        compare_all();
    endtask

    // Clock with en=1 until the PRESCALE=4 instance strobes; expect it after
    // exactly exp edges.
    task automatic count_to_step(input string tag, input int exp);
        int  n = 0;
        bit  found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            n++;
            if (sp_o[0]) found = 1;
        end
        if (!found) check({tag, "_timeout"}, 0, 1);
        else        check(tag, n, exp);
    endtask

    task automatic do_load(input logic [2:0] v);
        load     = 1'b1;
        load_val = v;
        cycle();
        load     = 1'b0;
    endtask

    initial begin
        int en_pat [7] = '{1, 0, 0, 1, 1, 1, 1};
        int n_en;
        bit seen;

        model_reset();
        #2;
        check("rst_sel", int'(sel_o[0]), 0);
        check("rst_dir", int'(dir_o[0]), 0);
        check("rst_sp",  int'(sp_o[0]),  0);
        check("rst_wr",  int'(wr_o[0]),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up count: full 0..7,0 walk with a wrap on 7->0.
        en   = 1'b1;
        mode = 2'b00;
        count_to_step("up_first_step", 4);
        repeat (36) cycle();

        // Ping-pong from a clean start: two full bounces on the fast instance.
        do_load(3'd0);
        mode = 2'b10;
        repeat (20) cycle();

        // Load colliding with a tick of the PRESCALE=4 instance.
        mode = 2'b00;
        for (int i = 0; i < 8 && m_ps[0] != 3; i++) cycle();
        check("ld_tick_align", m_ps[0], 3);
        do_load(3'd5);
        check("ld_sel",  int'(sel_o[0]), 5);
        check("ld_sp",   int'(sp_o[0]),  0);
        check("ld_wrap", int'(wr_o[0]),  0);
        count_to_step("ld_next_step", 4);

        // Enable gating: the step needs four cumulative enabled cycles.
        en = 1'b0;
        do_load(3'd2);
        n_en = 0;
        seen = 0;
        for (int i = 0; i < 7 && !seen; i++) begin
            en = en_pat[i][0];
            if (en) n_en++;
            cycle();
            if (sp_o[0]) seen = 1;
        end
        check("gate_seen", int'(seen), 1);
        check("gate_en_cycles", n_en, 4);
        en = 1'b1;

        // Down from 0 wraps to 7, then hold keeps it there.
        do_load(3'd0);
        mode = 2'b01;
        count_to_step("down_step", 4);
        check("down_sel",  int'(sel_o[0]), 7);
        check("down_wrap", int'(wr_o[0]),  1);
        mode = 2'b11;
        repeat (20) cycle();
        check("hold_sel", int'(sel_o[0]), 7);

        // Async reset while the fast instance sits at sel=6 descending.
        do_load(3'd0);
        mode = 2'b10;
        repeat (8) cycle();
        check("pre_rst_sel", int'(sel_o[1]), 6);
        check("pre_rst_dir", int'(dir_o[1]), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_sel", int'(sel_o[1]), 0);
        check("arst_dir", int'(dir_o[1]), 0);
        check("arst_sp",  int'(sp_o[1]),  0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 2'b00;
        count_to_step("arst_first_step", 4);

        // Randomised traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            mode     = 2'($urandom_range(0, 3));
            load     = ($urandom_range(0, 19) == 0);
            load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
            end else begin
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_sequencer3.md
Name: step_sequencer3

Overview:
- Upstream stage for the 3-to-8 LED decoder: a clocked 3-bit index generator.
- Its sel[2:0] output drives the decoder's three select inputs, so exactly one LED lights and the lit LED steps over time.
- Supports up, down, ping-pong and hold modes, a programmable step prescaler, and synchronous load.
- Emits per-step and per-cycle strobes for downstream logic.

Parameters:
- PRESCALE, 4: enabled clock cycles per step; legal range 1..65535. PRESCALE=1 means a step on every enabled cycle.
- PS_W, $clog2(PRESCALE) min 1: prescaler width. Derived; not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  prescaler advance enable.
- mode  in  2  00 up, 01 down, 10 ping-pong, 11 hold.
- load  in  1  synchronous load strobe.
- load_val  in  3  value loaded into sel.
- sel  out  3  current index, to the decoder select inputs.
- dir  out  1  ping-pong direction: 0 = ascending, 1 = descending.
- step_pulse  out  1  one-cycle strobe on each cycle sel takes a stepped value.
- wrap  out  1  one-cycle strobe on completion of a full sequence.

Behaviour:
- Reset (asynchronous, rst_n low): sel=0, dir=0, step_pulse=0, wrap=0, prescaler=0. Reset mid-step discards the partial prescale count.
- Prescaler:
  - Increments only on cycles with en=1.
  - tick is asserted when the prescaler equals PRESCALE-1 and en=1; the prescaler then returns to 0.
  - en=0 freezes the prescaler and sel; no strobes are issued.
- Step on tick; sel updates at the same edge; everything is registered, so there is zero extra latency:
  - up: sel+1 mod 8.
  - down: sel-1 mod 8.
  - ping-pong: moves in direction dir and reverses at the endpoints without repeating them. Sequence: 0,1,…,7,6,…,1,0,1…
    - At sel=7 with dir=0: next sel=6, dir becomes 1.
    - At sel=0 with dir=1: next sel=1, dir becomes 0.
  - hold: sel unchanged, prescaler still runs, step_pulse and wrap stay 0.
- step_pulse: registered; high for exactly the one cycle after a tick in modes 00, 01 and 10.
- wrap: registered, coincident with step_pulse. Asserted when:
  - up: sel goes 7→0;
  - down: sel goes 0→7;
  - ping-pong: sel leaves 0 upward after a descending pass (dir 1→0).
- Load:
  - load=1 sets sel=load_val, prescaler=0, dir=0.
  - load has priority over a coincident tick; no step_pulse or wrap that cycle.
  - load acts regardless of en.
- Mode change: takes effect at the next tick. dir is kept across mode changes, but dir is used only in ping-pong.
- Entering ping-pong with dir=1 at sel=0 follows the normal reversal rule: next sel=1, wrap=1.
- Outputs sel and dir come directly from flops; no combinational path exists from inputs to outputs.

Decomposition:
- Package step_seq_pkg:
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11;
  - SEL_MAX=3'd7; SEL_W=3.
- Sub-module tick_divider (parameter PRESCALE):
  - inputs clk, rst_n, en, clear; output tick;
  - clear is driven by load.
- Top level: the sequencing FSM (dir flop plus next-sel logic) and the strobe registers.

Test Plan:
- Up count, PRESCALE=4: release reset, en=1, mode=00. Expect sel=0,1,2,…,7,0 with changes every 4 cycles; step_pulse high 1 cycle per change; wrap=1 only on the 7→0 step; decoder one-hot walks LED1..LED8.
- Ping-pong, PRESCALE=1: en=1, mode=10. Expect sel 0,1,…,7,6,…,0,1; dir goes to 1 on the step to 6 and back to 0 on the step to 1; wrap high on the 0→1 step after the descent.
- Load collision: load=1, load_val=5 on the same cycle as a tick. Expect sel=5 next cycle, step_pulse=0, wrap=0, prescaler=0; the next step follows 4 enabled cycles later.
- Enable gating: en toggles 1,0,0,1,1 mid-prescale. Expect the count frozen while en=0; the step occurs after exactly 4 cumulative en=1 cycles; no strobes while en=0.
- Down/hold: mode=01 from sel=0 gives sel=7 with wrap=1; switching to mode=11 holds sel at 7 over 20 cycles with step_pulse=0.
- Async reset mid-operation: drop rst_n between edges while sel=6 and dir=1. Expect sel=0, dir=0 and strobes=0 immediately, without waiting for a clk edge; after release, the first step comes 4 enabled cycles later.
